// File: rtl/branch_target_predictor_if.sv
// Branch target predictor bus.
//   master : fetch/execute side; drives lookup (rd_*) and resolved-branch update (upd_*),
//            receives the registered prediction (pred_*).
//   slave  : the predictor itself.
interface branch_target_predictor_if;
  logic        rd_en;
  logic [31:0] rd_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output rd_en, rd_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_taken, pred_target, pred_hit
  );

  modport slave (
    input  rd_en, rd_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_taken, pred_target, pred_hit
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; clears all valid bits and the lookup outputs
//   bus   : slave side of branch_target_predictor_if
//           rd_en/rd_pc      -> one-cycle registered lookup (pred_hit/pred_taken/pred_target)
//           upd_valid/upd_*  -> resolved branch training, committed at the same edge
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 256,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  branch_target_predictor_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CtrMax  = '1;
  localparam logic [CTR_W-1:0] CtrZero = '0;
  localparam logic [CTR_W-1:0] CtrWeak = CTR_W'(1) << (CTR_W - 1);

  // Table storage; only valid_q is reset, the rest is qualified by it.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;

  assign rd_idx  = bus.rd_pc[IDX_W+1:2];
  assign rd_tag  = bus.rd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Bits of the update bus that the table never stores.
  logic unused_upd_bits;
  assign unused_upd_bits = ^{bus.upd_pc, bus.upd_target[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: read the pre-update table contents, register on enabled edges.
  // ---------------------------------------------------------------------------
  logic        hit_d, taken_d;
  logic [31:0] target_d;
  logic        hit_q, taken_q;
  logic [31:0] target_q_out;

  always_comb begin
    hit_d    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    taken_d  = hit_d && ctr_q[rd_idx][CTR_W-1];
    target_d = taken_d ? {target_q[rd_idx], 2'b00} : (bus.rd_pc + 32'd4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q        <= 1'b0;
      taken_q      <= 1'b0;
      target_q_out <= 32'h0;
    end else if (bus.rd_en) begin
      hit_q        <= hit_d;
      taken_q      <= taken_d;
      target_q_out <= target_d;
    end
  end

  assign bus.pred_hit    = hit_q;
  assign bus.pred_taken  = taken_q;
  assign bus.pred_target = target_q_out;

  // ---------------------------------------------------------------------------
  // Update: compute the new contents of the single entry being trained.
  // ---------------------------------------------------------------------------
  logic             upd_hit;
  logic             wr_en;
  logic [CTR_W-1:0] wr_ctr;
  logic [29:0]      wr_target;

  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    wr_en     = 1'b0;
    wr_ctr    = ctr_q[upd_idx];
    wr_target = target_q[upd_idx];
    if (bus.upd_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (bus.upd_taken) begin
          wr_target = bus.upd_target[31:2];
          if (ctr_q[upd_idx] != CtrMax) wr_ctr = ctr_q[upd_idx] + CTR_W'(1);
        end else begin
          if (ctr_q[upd_idx] != CtrZero) wr_ctr = ctr_q[upd_idx] - CTR_W'(1);
        end
      end else if (bus.upd_taken) begin
        // Allocate on a taken miss, evicting whatever lived at this index.
        wr_en     = 1'b1;
        wr_ctr    = CtrWeak;
        wr_target = bus.upd_target[31:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
      ctr_q[upd_idx]    <= wr_ctr;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_target_predictor_if bus_if ();

  branch_target_predictor #(
    .ENTRIES (256),
    .TAG_W   (8),
    .CTR_W   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic        rd_en;
    logic [31:0] rd_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        chk;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  localparam logic [31:0] PcA = 32'h1C00_0010;
  localparam logic [31:0] PcB = 32'h1C00_0410;  // same index as PcA, other tag
  localparam logic [31:0] PcC = 32'h1C00_0020;
  localparam logic [31:0] PcD = 32'h1C00_0030;
  localparam logic [31:0] PcE = 32'h1C00_0040;

  task automatic add(input logic re, input logic [31:0] rp, input logic uv,
                     input logic [31:0] up, input logic ut, input logic [31:0] utg,
                     input logic chk, input logic eh, input logic et, input logic [31:0] etg);
    vec_t v;
    v.rd_en = re; v.rd_pc = rp; v.upd_valid = uv; v.upd_pc = up; v.upd_taken = ut;
    v.upd_target = utg; v.chk = chk; v.exp_hit = eh; v.exp_taken = et; v.exp_target = etg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic eh, input logic et,
                           input logic [31:0] etg);
    check({name, " hit"},    {31'b0, bus_if.pred_hit},   {31'b0, eh});
    check({name, " taken"},  {31'b0, bus_if.pred_taken}, {31'b0, et});
    check({name, " target"}, bus_if.pred_target, etg);
  endtask

  task automatic drive(input logic re, input logic [31:0] rp, input logic uv,
                       input logic [31:0] up, input logic ut, input logic [31:0] utg);
    bus_if.rd_en = re; bus_if.rd_pc = rp; bus_if.upd_valid = uv;
    bus_if.upd_pc = up; bus_if.upd_taken = ut; bus_if.upd_target = utg;
  endtask

  // One edge: inputs already driven; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rd_en re upd_v upd_pc taken upd_target | chk hit taken target
    add(1, 32'h1C00_0000, 0, 0,   0, 0,            1, 0, 0, 32'h1C00_0004);
    add(0, 0,             1, PcA, 1, 32'h1C00_0100, 1, 0, 0, 32'h1C00_0004);
    add(1, PcA,           0, 0,   0, 0,            1, 1, 1, 32'h1C00_0100);
    add(1, PcA,           1, PcA, 0, 0,            1, 1, 1, 32'h1C00_0100);
    add(1, PcA,           1, PcA, 0, 0,            1, 1, 0, 32'h1C00_0014);
    add(1, PcA,           0, 0,   0, 0,            1, 1, 0, 32'h1C00_0014);
    // Saturation: 5 taken (0->3), outputs held meanwhile.
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, PcA, 1, 32'h1C00_0200, (i == 4), 1, 0, 32'h1C00_0014);
    add(1, PcA,           1, PcA, 0, 0,            1, 1, 1, 32'h1C00_0200);
    add(1, PcA,           0, 0,   0, 0,            1, 1, 1, 32'h1C00_0200);
    for (int i = 0; i < 4; i++)
      add(0, 0, 1, PcA, 0, 0, 0, 0, 0, 0);
    add(1, PcA,           1, PcA, 1, 32'h1C00_0200, 1, 1, 0, 32'h1C00_0014);
    add(1, PcA,           0, 0,   0, 0,            1, 1, 0, 32'h1C00_0014);
    // Aliasing.
    add(0, 0,             1, PcB, 1, 32'h1C00_0300, 0, 0, 0, 0);
    add(1, PcA,           0, 0,   0, 0,            1, 0, 0, 32'h1C00_0014);
    add(1, PcB,           0, 0,   0, 0,            1, 1, 1, 32'h1C00_0300);
    // Same-edge lookup and allocate.
    add(1, PcC,           1, PcC, 1, 32'h1C00_0400, 1, 0, 0, 32'h1C00_0024);
    add(1, PcC,           0, 0,   0, 0,            1, 1, 1, 32'h1C00_0400);
    // Not-taken miss does not allocate; upd_valid=0 ignores the rest.
    add(0, 0,             1, PcD, 0, 32'h1C00_0500, 0, 0, 0, 0);
    add(1, PcD,           0, PcD, 1, 32'h1C00_0500, 1, 0, 0, 32'h1C00_0034);
    add(1, PcD,           0, 0,   0, 0,            1, 0, 0, 32'h1C00_0034);
    // Fall-through wraps; low PC bits ignored.
    add(1, 32'hFFFF_FFFC, 0, 0,   0, 0,            1, 0, 0, 32'h0000_0000);
    add(1, 32'h1C00_0022, 0, 0,   0, 0,            1, 1, 1, 32'h1C00_0400);

    reset = 1'b1;
    drive(1, PcA, 1, PcA, 1, 32'h1C00_0100);
    tick();
    tick();
    check_out("reset", 0, 0, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_out("post-reset idle", 0, 0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd_en, vecs[i].rd_pc, vecs[i].upd_valid, vecs[i].upd_pc,
            vecs[i].upd_taken, vecs[i].upd_target);
      tick();
      if (vecs[i].chk)
        check_out($sformatf("row%0d", i), vecs[i].exp_hit, vecs[i].exp_taken,
                  vecs[i].exp_target);
    end

    // Hold while the held PC is trained down; outputs must not move.
    drive(1, PcC, 0, 0, 0, 0);
    tick();
    check_out("hold start", 1, 1, 32'h1C00_0400);
    for (int i = 0; i < 3; i++) begin
      drive(0, PcD, 1, PcC, 0, 0);
      tick();
      check_out($sformatf("hold%0d", i), 1, 1, 32'h1C00_0400);
    end

    // Reset mid-sequence wins over a lookup and an allocating update.
    reset = 1'b1;
    drive(1, PcC, 1, PcE, 1, 32'h1C00_0600);
    tick();
    check_out("mid reset", 0, 0, 32'h0);
    reset = 1'b0;
    drive(1, PcC, 0, 0, 0, 0);
    tick();
    check_out("after reset C", 0, 0, 32'h1C00_0024);
    drive(1, PcE, 0, 0, 0, 0);
    tick();
    check_out("after reset E", 0, 0, 32'h1C00_0044);
    drive(1, PcB, 0, 0, 0, 0);
    tick();
    check_out("after reset B", 0, 0, 32'h1C00_0414);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 256, number of predictor entries (power of two, 16..1024); IDX_W = log2(ENTRIES).
REQ-002 SHALL provide parameter TAG_W, default 8, tag bits stored per entry (1..32-IDX_W-2).
REQ-003 SHALL provide parameter CTR_W, default 2, saturating-counter width (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 rd_en  input  1  lookup enable; 0 = hold registered lookup outputs (pipeline stall).
REQ-007 rd_pc  input  32  PC to predict (next-fetch PC).
REQ-008 pred_taken  output  1  registered prediction for the rd_pc sampled at the previous enabled edge.
REQ-009 pred_target  output  32  registered predicted fetch address.
REQ-010 pred_hit  output  1  registered tag hit for the looked-up PC.
REQ-011 upd_valid  input  1  a branch/jump resolved this cycle in EX.
REQ-012 upd_pc  input  32  PC of the resolved branch.
REQ-013 upd_taken  input  1  actual direction of the resolved branch.
REQ-014 upd_target  input  32  actual target of the resolved branch.

Function
REQ-015 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-016 Each entry SHALL hold valid (1b), tag (TAG_W), target[31:2] (30b), counter (CTR_W).
REQ-017 Lookup SHALL take 1 cycle: on an edge with rd_en=1, outputs SHALL reflect rd_pc present before that edge.
REQ-018 pred_hit SHALL be 1 iff the indexed entry is valid and its tag equals the rd_pc tag.
REQ-019 pred_taken SHALL be pred_hit AND counter MSB.
REQ-020 pred_target SHALL be {target,2'b00} when pred_taken=1, otherwise sampled rd_pc+4 (32-bit wrap, 0xFFFFFFFC+4 = 0x00000000).
REQ-021 With rd_en=0 all three lookup outputs SHALL hold their values, even if the table is updated.
REQ-022 Update hit (upd_valid, entry valid, tag match): counter SHALL increment on taken, decrement on not-taken, saturating at 2^CTR_W-1 and 0.
REQ-023 Update hit with upd_taken=1 SHALL also overwrite target with upd_target[31:2].
REQ-024 Update miss with upd_taken=1 SHALL allocate: valid=1, tag and target written, counter = 2^(CTR_W-1) (weakly taken), replacing any previous occupant.
REQ-025 Update miss with upd_taken=0 SHALL leave the table unchanged.
REQ-026 Update SHALL be committed at the edge where upd_valid=1; at most one update per cycle.
REQ-027 Lookup and update to the same index at the same edge SHALL be read-before-write: lookup returns the pre-update entry.
REQ-028 A lookup at the edge after an update SHALL see the updated entry.
REQ-029 upd_taken/upd_pc/upd_target SHALL be ignored when upd_valid=0.

Reset
REQ-030 On an edge with reset=1, all valid bits SHALL clear in that single cycle; pred_taken=0, pred_hit=0, pred_target=0x00000000.
REQ-031 Reset SHALL take priority over simultaneous rd_en and upd_valid; no update commits on a reset edge.
REQ-032 Tag, target and counter storage need not be reset; they SHALL be unobservable until their entry is written with valid=1.
REQ-033 First lookup after reset deasserts SHALL predict not-taken with pred_target = rd_pc+4.

Verification (ENTRIES=256, TAG_W=8, CTR_W=2)
REQ-034 Reset, then lookup 0x1C000000 -> next cycle pred_hit=0, pred_taken=0, pred_target=0x1C000004.
REQ-035 Update pc=0x1C000010 taken target=0x1C000100, then lookup 0x1C000010 -> pred_hit=1, pred_taken=1, pred_target=0x1C000100; 2 not-taken updates -> pred_taken=0, pred_hit=1.
REQ-036 Counter saturation: 5 taken updates to one PC, then 1 not-taken -> still pred_taken=1; 4 more not-taken, then 1 taken -> pred_taken=0.
REQ-037 Aliasing: allocate 0x1C000010, then taken update 0x1C000410 (same index, different tag) -> lookup 0x1C000010 gives pred_hit=0; lookup 0x1C000410 gives pred_hit=1.
REQ-038 Same-edge lookup and allocate of 0x1C000020 -> that lookup gives pred_hit=0; the lookup one cycle later gives pred_hit=1.
REQ-039 rd_en=0 for 3 cycles while updating the held PC -> outputs unchanged; reset asserted mid-sequence -> all outputs 0 and all subsequent lookups miss.
